// File: rtl/mcu_system_cpu_cpu_debug_host.sv
// Virtual JTAG host: runs one UIR/CDR/SDR/UDR/RTI scan per accepted request.
// Optional macro DEBUG_HOST_IR_SKIP_EN skips the UIR period when the IR is unchanged.
module mcu_system_cpu_cpu_debug_host #(
  parameter int TCK_DIV  = 4,
  parameter int DR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CW = $clog2(DR_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
  } state_t;

  state_t              state_reg, state_next;
  logic [7:0]          div_reg;
  logic                tck_reg;
  logic                tdi_reg;
  logic [1:0]          ir_reg;
  logic                started_reg;
  logic [CW-1:0]       cnt_reg;
  logic [DR_WIDTH-1:0] shift_reg;
  logic [DR_WIDTH-1:0] cap_reg;
  logic [DR_WIDTH-1:0] rsp_dr_reg;

  logic running, tick, rise_ev, fall_ev, accept, skip_uir;

  assign running = (state_reg != S_IDLE) && (state_reg != S_RESP);
  assign tick    = running && (div_reg == 8'(TCK_DIV - 1));
  assign rise_ev = tick && !tck_reg;
  assign fall_ev = tick && tck_reg;
  assign accept  = cmd_valid && cmd_ready;

`ifdef DEBUG_HOST_IR_SKIP_EN
  logic done_once_reg;
  assign skip_uir = done_once_reg && (cmd_ir == ir_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      done_once_reg <= 1'b0;
    else if (state_reg == S_RESP)
      done_once_reg <= 1'b1;
  end
`else
  assign skip_uir = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    vji_uir    = 1'b0;
    vji_cdr    = 1'b0;
    vji_sdr    = 1'b0;
    vji_udr    = 1'b0;
    vji_rti    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cmd_ready = started_reg;
        if (accept)
          state_next = skip_uir ? S_CDR : S_UIR;
      end
      S_UIR: begin
        vji_uir = 1'b1;
        if (fall_ev) state_next = S_CDR;
      end
      S_CDR: begin
        vji_cdr = 1'b1;
        if (fall_ev) state_next = S_SDR;
      end
      S_SDR: begin
        vji_sdr = 1'b1;
        if (fall_ev && (cnt_reg == CW'(DR_WIDTH))) state_next = S_UDR;
      end
      S_UDR: begin
        vji_udr = 1'b1;
        if (fall_ev) state_next = S_RTI;
      end
      S_RTI: begin
        vji_rti = 1'b1;
        if (fall_ev) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // TCK divider: free-runs only during the scan states, parked low otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= '0;
      tck_reg <= 1'b0;
    end else if (!running) begin
      div_reg <= '0;
      tck_reg <= 1'b0;
    end else if (tick) begin
      div_reg <= '0;
      tck_reg <= ~tck_reg;
    end else begin
      div_reg <= div_reg + 8'd1;
    end
  end

  // Shift datapath: TDI moves on fall events, TDO is captured on rise events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_reg <= 1'b0;
      tdi_reg     <= 1'b0;
      ir_reg      <= 2'b00;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      cap_reg     <= '0;
      rsp_dr_reg  <= '0;
    end else begin
      started_reg <= 1'b1;
      if (accept) begin
        ir_reg    <= cmd_ir;
        shift_reg <= cmd_dr;
      end
      if (state_reg == S_CDR && fall_ev) begin
        tdi_reg   <= shift_reg[0];
        shift_reg <= shift_reg >> 1;
        cnt_reg   <= '0;
      end
      if (state_reg == S_SDR && rise_ev) begin
        cap_reg <= {vji_tdo, cap_reg[DR_WIDTH-1:1]};
        if (cnt_reg < CW'(DR_WIDTH))
          cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == S_SDR && fall_ev) begin
        if (cnt_reg == CW'(DR_WIDTH)) begin
          tdi_reg <= 1'b0;
        end else begin
          tdi_reg   <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
        end
      end
      if (state_reg == S_RTI && fall_ev)
        rsp_dr_reg <= cap_reg;
    end
  end

  assign vji_tck   = tck_reg;
  assign vji_tdi   = tdi_reg;
  assign vji_ir_in = ir_reg;
  assign rsp_dr    = rsp_dr_reg;

endmodule

// File: tb/tb_mcu_system_cpu_cpu_debug_host.sv
// Directed bench for mcu_system_cpu_cpu_debug_host (TCK_DIV=4, DR_WIDTH=38).
module tb_mcu_system_cpu_cpu_debug_host;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_dr;
  logic        rsp_valid;
  logic [37:0] rsp_dr;
  logic        vji_tck, vji_tdi, vji_tdo;
  logic [1:0]  vji_ir_in;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  int passed = 0;
  int total  = 0;
  int tdo_mode = 0;  // 0 loopback, 1 tied high, 2 tied low

  assign vji_tdo = (tdo_mode == 0) ? vji_tdi : (tdo_mode == 1);

  mcu_system_cpu_cpu_debug_host #(.TCK_DIV(4), .DR_WIDTH(38)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_dr(rsp_dr),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

  // Monitor: strobe order, per-strobe cycle counts and protocol invariants.
  longint seq_code = 0;
  int     strb_cyc [5];
  int     rsp_count = 0;
  int     onehot_err = 0, tdi_err = 0, coinc_err = 0, edge_err = 0;
  logic [4:0] prev_strb = '0;
  logic   prev_tck = 1'b0, prev_ready = 1'b0, prev_rstn = 1'b0;

  always @(negedge clk) begin
    logic [4:0] strb;
    strb = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};
    if (strb != prev_strb && strb != 5'd0)
      for (int i = 0; i < 5; i++)
        if (strb[i]) seq_code = seq_code * 8 + i + 1;
    for (int i = 0; i < 5; i++)
      if (strb[i]) strb_cyc[i]++;
    if ($countones(strb) > 1) onehot_err++;
    if (vji_tdi && !vji_sdr) tdi_err++;
    if (rsp_valid && cmd_ready) coinc_err++;
    if (rsp_valid) rsp_count++;
    if (reset_n && prev_rstn && strb != prev_strb && !(prev_tck && !vji_tck) && !prev_ready)
      edge_err++;
    prev_strb  = strb;
    prev_tck   = vji_tck;
    prev_ready = cmd_ready;
    prev_rstn  = reset_n;
  end

  task automatic clear_mon();
    seq_code = 0;
    for (int i = 0; i < 5; i++) strb_cyc[i] = 0;
    rsp_count = 0;
    onehot_err = 0; tdi_err = 0; coinc_err = 0; edge_err = 0;
  endtask

  // Starts at a negedge; returns clk edges from acceptance to rsp_valid inclusive.
  task automatic run_scan(input logic [1:0] ir, input logic [37:0] dr,
                          output int cyc, output logic [37:0] rsp);
    int w = 0;
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 2000) begin @(negedge clk); cyc++; end
    rsp = rsp_dr;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_dr = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
         rsp_valid, cmd_ready} !== 11'd0 || rsp_dr !== 38'd0) begin
      $display("FAIL reset_outputs: tck=%b tdi=%b ir=%b strobes=%b%b%b%b%b rsp_valid=%b ready=%b rsp_dr=%h required all 0",
               vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
               rsp_valid, cmd_ready, rsp_dr);
    end else passed++;
    reset_n = 1'b1; #1;
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_after_first_edge: got %b required 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_loopback();
    int cyc; logic [37:0] rsp;
    clear_mon(); tdo_mode = 0;
    run_scan(2'b01, 38'h2_5A5A_A5A5, cyc, rsp);
    total++;
    if (rsp !== 38'h2_5A5A_A5A5) $display("FAIL loop_data: got %h required %h", rsp, 38'h2_5A5A_A5A5);
    else passed++;
    total++;
    if (cyc !== 337) $display("FAIL loop_latency: got %0d clks required 337", cyc);
    else passed++;
    total++;
    if (rsp_count !== 1) $display("FAIL loop_rsp_pulses: got %0d required 1", rsp_count);
    else passed++;
    total++;
    if (vji_ir_in !== 2'b01) $display("FAIL loop_ir_hold: got %b required 01", vji_ir_in);
    else passed++;
    total++;
    if (rsp_dr !== 38'h2_5A5A_A5A5 || rsp_valid !== 1'b0)
      $display("FAIL loop_rsp_hold: rsp_dr=%h rsp_valid=%b required %h and 0", rsp_dr, rsp_valid, 38'h2_5A5A_A5A5);
    else passed++;
  endtask

  task automatic test_ones_states();
    int cyc; logic [37:0] rsp;
    clear_mon(); tdo_mode = 1;
    run_scan(2'b11, 38'h00_1234_0000, cyc, rsp);
    total++;
    if (rsp !== {38{1'b1}}) $display("FAIL ones_data: got %h required %h", rsp, {38{1'b1}});
    else passed++;
    total++;
    if (seq_code !== 64'o12345) $display("FAIL ones_order: got %o required 12345", seq_code);
    else passed++;
    total++;
    if (strb_cyc[0] !== 8 || strb_cyc[1] !== 8 || strb_cyc[2] !== 304 || strb_cyc[3] !== 8 || strb_cyc[4] !== 8)
      $display("FAIL ones_periods: uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d clks required 8 8 304 8 8",
               strb_cyc[0], strb_cyc[1], strb_cyc[2], strb_cyc[3], strb_cyc[4]);
    else passed++;
    total++;
    if (onehot_err !== 0 || tdi_err !== 0 || edge_err !== 0 || coinc_err !== 0)
      $display("FAIL ones_invariants: onehot=%0d tdi=%0d edge=%0d coinc=%0d required 0 0 0 0",
               onehot_err, tdi_err, edge_err, coinc_err);
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    int w = 0; int cyc; logic [37:0] rsp;
    clear_mon(); tdo_mode = 0;
    cmd_ir = 2'b10; cmd_dr = 38'h3F_FFFF_FFFF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!vji_sdr && w < 200) begin @(negedge clk); w++; end
    repeat (20 * 8 + 3) @(negedge clk);
    reset_n = 1'b0; #1;
    total++;
    if ({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
         rsp_valid, cmd_ready} !== 11'd0 || rsp_dr !== 38'd0) begin
      $display("FAIL midreset_outputs: tck=%b tdi=%b ir=%b strobes=%b%b%b%b%b rsp_valid=%b ready=%b rsp_dr=%h required all 0",
               vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
               rsp_valid, cmd_ready, rsp_dr);
    end else passed++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (rsp_count !== 0) $display("FAIL midreset_no_rsp: got %0d pulses required 0", rsp_count);
    else passed++;
    run_scan(2'b11, 38'h0F_0F0F_F00F, cyc, rsp);
    total++;
    if (rsp !== 38'h0F_0F0F_F00F || cyc !== 337)
      $display("FAIL midreset_rescan: got %h/%0d clks required %h/337", rsp, cyc, 38'h0F_0F0F_F00F);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_mon(); tdo_mode = 2;
    cmd_ir = 2'b01; cmd_dr = 38'h15_5555_5555; cmd_valid = 1'b1;
    while (rsp_count < 3 && n < 1500) begin @(negedge clk); #1; n++; end
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (rsp_count !== 3) $display("FAIL b2b_pulses: got %0d required 3", rsp_count);
    else passed++;
    total++;
    if (n !== 1013) $display("FAIL b2b_timing: third rsp after %0d clks required 1013", n);
    else passed++;
    total++;
    if (coinc_err !== 0 || edge_err !== 0)
      $display("FAIL b2b_ready_rsp: coinc=%0d edge=%0d required 0 0", coinc_err, edge_err);
    else passed++;
    total++;
    if (rsp_dr !== 38'd0) $display("FAIL b2b_data: got %h required 0", rsp_dr);
    else passed++;
  endtask

  task automatic test_ir_skip();
    int cyc1, cyc2; logic [37:0] rsp; longint s1, s2;
    int exp_cyc2; longint exp_s2;
`ifdef DEBUG_HOST_IR_SKIP_EN
    exp_cyc2 = 329; exp_s2 = 64'o2345;
`else
    exp_cyc2 = 337; exp_s2 = 64'o12345;
`endif
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tdo_mode = 0;
    clear_mon();
    run_scan(2'b10, 38'h01_2345_6789, cyc1, rsp);
    s1 = seq_code;
    clear_mon();
    run_scan(2'b10, 38'h3A_BCDE_F012, cyc2, rsp);
    s2 = seq_code;
    total++;
    if (s1 !== 64'o12345 || cyc1 !== 337)
      $display("FAIL irskip_first: order %o/%0d clks required 12345/337", s1, cyc1);
    else passed++;
    total++;
    if (s2 !== exp_s2 || cyc2 !== exp_cyc2)
      $display("FAIL irskip_second: order %o/%0d clks required %o/%0d", s2, cyc2, exp_s2, exp_cyc2);
    else passed++;
    total++;
    if (rsp !== 38'h3A_BCDE_F012 || vji_ir_in !== 2'b10)
      $display("FAIL irskip_data: got %h ir=%b required %h ir=10", rsp, vji_ir_in, 38'h3A_BCDE_F012);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_ones_states();
    test_reset_mid_scan();
    test_back_to_back();
    test_ir_skip();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
